// File: rtl/panel_input_pkg.sv
// Shared constants, event record and helpers for the panel input conditioner.
package panel_input_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int REPEAT_CYCLES_DEFAULT   = 25000000;

    // Event fields are sized for up to 32 buttons / 32 switches and narrowed at the ports
    localparam int PANEL_BTN_IDX_MAX_W = 5;
    localparam int PANEL_SW_MAX_W      = 32;

    typedef struct packed {
        logic [PANEL_BTN_IDX_MAX_W-1:0] btn;
        logic [PANEL_SW_MAX_W-1:0]      sw;
    } panel_evt_t;

    function automatic logic [PANEL_BTN_IDX_MAX_W-1:0] lowest_set(input logic [31:0] v);
        logic [PANEL_BTN_IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = PANEL_BTN_IDX_MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button input: two-flop synchronizer, stability counter, debounced level and rise pulse.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk100,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Level follows the synchronized input only after DEBOUNCE_CYCLES consecutive disagreements
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else if (sync_p1 == level) begin
            cnt  <= '0;
            rise <= 1'b0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync_p1;
            rise  <= sync_p1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            rise <= 1'b0;
        end
    end

endmodule

// File: rtl/panel_input_conditioner.sv
// Debounces panel buttons/switches and turns each press into a single valid/ready event.
// Define PANEL_AUTO_REPEAT_EN to re-pulse btn_press every REPEAT_CYCLES while a button is held.
module panel_input_conditioner
    import panel_input_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int SW_W            = 24,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic                       clk100,
    input  logic                       reset_n,
    input  logic [NUM_BTN-1:0]         btn,
    input  logic [SW_W-1:0]            sw,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_press,
    output logic [SW_W-1:0]            sw_stable,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_btn,
    output logic [SW_W-1:0]            evt_sw,
    output logic                       evt_overflow
);

    localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int BTN_IDX_W = $clog2(NUM_BTN);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("panel_input_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end

    logic [NUM_BTN-1:0] btn_rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk100  (clk100),
            .reset_n (reset_n),
            .raw     (btn[i]),
            .level   (btn_level[i]),
            .rise    (btn_rise[i])
        );
    end

`ifdef PANEL_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0]   rep_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] rep_pulse;

    // rep_cnt counts cycles since the last visible pulse; it restarts at 1 on each pulse
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) rep_cnt[i] <= '0;
            rep_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!btn_level[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_pulse[i] <= 1'b0;
                end else begin
                    rep_pulse[i] <= !btn_press[i] && (rep_cnt[i] == REP_W'(REPEAT_CYCLES - 1));
                    rep_cnt[i]   <= btn_press[i] ? REP_W'(1) : rep_cnt[i] + REP_W'(1);
                end
            end
        end
    end

    assign btn_press = btn_rise | (rep_pulse & btn_level);
`else
    assign btn_press = btn_rise;
`endif

    // Switch vector: synchronizer, then one shared counter so the whole group loads at once
    logic [SW_W-1:0]  sw_p0;
    logic [SW_W-1:0]  sw_p1;
    logic [CNT_W-1:0] sw_cnt;

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            sw_p0     <= '0;
            sw_p1     <= '0;
            sw_cnt    <= '0;
            sw_stable <= '0;
        end else begin
            sw_p0 <= sw;
            sw_p1 <= sw_p0;
            if (sw_p1 == sw_stable || sw_p1 != sw_p0) begin
                sw_cnt <= '0;
            end else if (sw_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                sw_cnt    <= '0;
                sw_stable <= sw_p1;
            end else begin
                sw_cnt <= sw_cnt + CNT_W'(1);
            end
        end
    end

    // Single-entry event register
    panel_evt_t evt_q;
    logic       any_press;
    logic       multi_press;
    logic       evt_load;

    assign any_press   = |btn_press;
    assign multi_press = |(btn_press & (btn_press - NUM_BTN'(1)));
    assign evt_load    = any_press && (!evt_valid || evt_ready);

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            evt_q        <= '0;
            evt_valid    <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            if (evt_load) begin
                evt_q.btn <= lowest_set(32'(btn_press));
                evt_q.sw  <= PANEL_SW_MAX_W'(sw_stable);
                evt_valid <= 1'b1;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (any_press && (!evt_load || multi_press)) evt_overflow <= 1'b1;
        end
    end

    assign evt_btn = BTN_IDX_W'(evt_q.btn);
    assign evt_sw  = SW_W'(evt_q.sw);

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus against a window-based reference model.
module tb_panel_input_conditioner;

    localparam int NB = 5;
    localparam int SWW = 24;
    localparam int DB = 4;
    localparam int RP = 10;
    localparam int HIST = 12;
    localparam int VW = NB + NB + SWW + 1 + 3 + SWW + 1;

    logic           clk100 = 1'b0;
    logic           reset_n = 1'b1;
    logic [NB-1:0]  btn = '0;
    logic [SWW-1:0] sw = '0;
    logic           evt_ready = 1'b0;
    logic [NB-1:0]  btn_level;
    logic [NB-1:0]  btn_press;
    logic [SWW-1:0] sw_stable;
    logic           evt_valid;
    logic [2:0]     evt_btn;
    logic [SWW-1:0] evt_sw;
    logic           evt_overflow;

    int n_tests = 0;
    int n_fail = 0;

    panel_input_conditioner #(
        .NUM_BTN(NB), .SW_W(SWW), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)
    ) dut (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .btn          (btn),
        .sw           (sw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .sw_stable    (sw_stable),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_sw       (evt_sw),
        .evt_overflow (evt_overflow)
    );

    always #5 clk100 = ~clk100;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {btn_level, btn_press, sw_stable, evt_valid, evt_btn, evt_sw, evt_overflow};

    // Reference model: raw input history plus the resulting outputs
    logic [NB-1:0]  h_btn[$];
    logic [SWW-1:0] h_sw[$];
    logic [NB-1:0]  m_level, m_press;
    logic [SWW-1:0] m_stable, m_sw;
    logic           m_valid, m_ovf;
    logic [2:0]     m_btn;
    int             m_since[NB];

    function automatic logic [VW-1:0] model_vec();
        return {m_level, m_press, m_stable, m_valid, m_btn, m_sw, m_ovf};
    endfunction

    task automatic model_reset();
        m_level = '0; m_press = '0; m_stable = '0; m_sw = '0;
        m_valid = 1'b0; m_ovf = 1'b0; m_btn = '0;
        for (int i = 0; i < NB; i++) m_since[i] = 0;
        h_btn.delete(); h_sw.delete();
        for (int k = 0; k < HIST; k++) begin
            h_btn.push_back('0);
            h_sw.push_back('0);
        end
    endtask

    // Advance one clock: model consumes the inputs present before the edge.
    // A level flips once the synchronized input (raw delayed 2) disagreed for DB samples;
    // the switch vector loads once DB+1 consecutive raw samples were identical and new.
    task automatic tick();
        logic [NB-1:0] p, np;
        int n;
        bit flip, same;
        p = m_press;
        if (p != '0) begin
            if (!m_valid || evt_ready) begin
                for (int i = NB - 1; i >= 0; i--) if (p[i]) m_btn = 3'(i);
                m_sw = m_stable;
                m_valid = 1'b1;
                if ($countones(p) > 1) m_ovf = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        h_btn.push_back(btn);
        h_sw.push_back(sw);
        while (h_btn.size() > HIST) h_btn.pop_front();
        while (h_sw.size() > HIST) h_sw.pop_front();
        n = h_btn.size();
        np = '0;
        for (int i = 0; i < NB; i++) begin
            flip = 1;
            for (int k = 2; k <= DB + 1; k++) if (h_btn[n-1-k][i] == m_level[i]) flip = 0;
            if (flip) begin
                m_level[i] = ~m_level[i];
                np[i] = m_level[i];
                m_since[i] = 0;
            end
`ifdef PANEL_AUTO_REPEAT_EN
            else if (m_level[i]) begin
                m_since[i]++;
                if (m_since[i] == RP) begin
                    np[i] = 1'b1;
                    m_since[i] = 0;
                end
            end
`endif
        end
        m_press = np;
        same = 1;
        for (int k = 1; k <= DB + 1; k++) if (h_sw[n-1-k] != h_sw[n-2]) same = 0;
        if (same && h_sw[n-2] != m_stable) m_stable = h_sw[n-2];
        @(posedge clk100);
        @(negedge clk100);
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        btn = '0; sw = '0; evt_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk100);
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", dut_vec);
        end
        reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++;
            if (dut_vec !== '0 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: got %h want %h", c, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        evt_ready = 1'b1;
        btn = 5'b00001;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_tests++;
            if (btn_level[0] !== (c >= 6) || btn_press[0] !== (c == 6) || evt_valid !== (c == 7)
                || (c == 7 && evt_btn !== 3'd0)) begin
                n_fail++;
                $display("FAIL clean_press c=%0d: got level=%b press=%b valid=%b btn=%0d want level=%b press=%b valid=%b btn=0",
                         c, btn_level[0], btn_press[0], evt_valid, evt_btn, c >= 6, c == 6, c == 7);
            end
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL clean_press_model c=%0d: got %h want %h", c, dut_vec, model_vec());
            end
        end
        btn = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (btn_press !== '0 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL release c=%0d: got %h want %h", c, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_glitch();
        btn = 5'b00010;
        repeat (3) tick();
        btn = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (btn_level !== '0 || btn_press !== '0 || evt_valid !== 1'b0 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL glitch c=%0d: got level=%b press=%b valid=%b want 0 0 0", c, btn_level, btn_press, evt_valid);
            end
        end
    endtask

    task automatic test_switch();
        logic [SWW-1:0] pat[4];
        int dur[4];
        pat = '{24'h00A5A5, 24'h00A5A4, 24'h00A5A5, 24'h000000};
        dur = '{2, 2, 2, 6};
        for (int s = 0; s < 4; s++) begin
            sw = pat[s];
            for (int c = 0; c < dur[s]; c++) begin
                tick();
                n_tests++;
                if (sw_stable !== '0 || dut_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL sw_bounce seg=%0d: got %h want 0", s, sw_stable);
                end
            end
        end
        sw = 24'h000F03;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (sw_stable !== ((c >= 6) ? 24'h000F03 : 24'h0) || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL sw_settle c=%0d: got %h want %h", c, sw_stable, (c >= 6) ? 24'h000F03 : 24'h0);
            end
        end
        btn = 5'b00100;
        repeat (7) tick();
        n_tests++;
        if (evt_valid !== 1'b1 || evt_btn !== 3'd2 || evt_sw !== 24'h000F03) begin
            n_fail++;
            $display("FAIL sw_event: got valid=%b btn=%0d sw=%h want 1 2 000f03", evt_valid, evt_btn, evt_sw);
        end
        btn = '0;
        repeat (8) tick();
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        btn = 5'b01000;
        repeat (7) tick();
        n_tests++;
        if (evt_valid !== 1'b1 || evt_btn !== 3'd3 || evt_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_first: got valid=%b btn=%0d ovf=%b want 1 3 0", evt_valid, evt_btn, evt_overflow);
        end
        btn = 5'b10000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (evt_valid !== 1'b1 || evt_btn !== 3'd3 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d: got valid=%b btn=%0d want 1 3", c, evt_valid, evt_btn);
            end
        end
        n_tests++;
        if (evt_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow: got %b want 1", evt_overflow);
        end
        btn = '0;
        evt_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (evt_valid !== 1'b0 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL bp_drain c=%0d: got valid=%b want 0", c, evt_valid);
            end
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        tick();
        n_tests++;
        if (evt_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_clear: got ovf=%b want 0", evt_overflow);
        end
        evt_ready = 1'b1;
        btn = 5'b01010;
        repeat (7) tick();
        n_tests++;
        if (evt_valid !== 1'b1 || evt_btn !== 3'd1 || evt_overflow !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL simul_event: got valid=%b btn=%0d ovf=%b want 1 1 1", evt_valid, evt_btn, evt_overflow);
        end
        tick();
        n_tests++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_single: got valid=%b want 0", evt_valid);
        end
        btn = '0;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        evt_ready = 1'b0;
        btn = 5'b00001;
        repeat (7) tick();
        sw = 24'h123456;
        repeat (3) tick();
        n_tests++;
        if (evt_valid !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL areset_pre: got %h want %h", dut_vec, model_vec());
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL areset_clear: got %h want 0", dut_vec);
        end
        #1 reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++;
            if (btn_level[0] !== (c >= 6) || btn_press[0] !== (c == 6) || evt_valid !== (c >= 7)
                || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL areset_redetect c=%0d: got level=%b press=%b valid=%b want %b %b %b",
                         c, btn_level[0], btn_press[0], evt_valid, c >= 6, c == 6, c >= 7);
            end
        end
        evt_ready = 1'b1;
        btn = '0;
        repeat (8) tick();
    endtask

    task automatic test_hold();
        logic exp;
        pulse_reset();
        evt_ready = 1'b1;
        btn = 5'b00001;
        for (int c = 1; c <= 40; c++) begin
            tick();
`ifdef PANEL_AUTO_REPEAT_EN
            exp = (c >= 6) && ((c - 6) % RP == 0);
`else
            exp = (c == 6);
`endif
            n_tests++;
            if (btn_press[0] !== exp || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL hold_press c=%0d: got %b want %b", c, btn_press[0], exp);
            end
        end
        btn = '0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 19) == 0) sw = 24'($urandom);
            else if ($urandom_range(0, 19) == 0) sw[$urandom_range(0, SWW - 1)] ^= 1'b1;
            evt_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random c=%0d: got %h want %h", c, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch();
        test_switch();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
